// File: rtl/bcd_conv_sequencer_if.sv
// bcd_conv_sequencer_if: valid/ready bundle carrying BCD words in and binary results out
interface bcd_conv_sequencer_if #(
   parameter int NDIG = 8,
   parameter int OUT_W = 27
);
   logic in_valid, in_ready, out_valid, out_ready, out_err;
   logic [4*NDIG-1:0] in_bcd;
   logic [OUT_W-1:0] out_bin;
   modport master(output in_valid, in_bcd, out_ready, input in_ready, out_valid, out_bin, out_err);
   modport slave(input in_valid, in_bcd, out_ready, output in_ready, out_valid, out_bin, out_err);
endinterface

// File: rtl/bcd_conv_sequencer.sv
// bcd_conv_sequencer: converts a packed BCD word to binary, one digit per cycle, MSD first
module bcd_conv_sequencer #(
   parameter int NDIG = 8,
   parameter int OUT_W = 27
) (
   input  logic clk,
   input  logic reset,
   bcd_conv_sequencer_if.slave b,
   output logic busy
);
   localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   state_t state;
   logic [4*NDIG-1:0] sr;
   logic [OUT_W-1:0] acc, nacc;
   logic [CW-1:0] cnt;
   logic [3:0] d;
   logic err, bad, last;
   always_comb begin
      d = sr[4*NDIG-1 -: 4];
      bad = d > 4'd9;
      nacc = (acc << 3) + (acc << 1) + OUT_W'(bad ? 4'd0 : d);
      last = cnt == CW'(NDIG - 1);
   end
   // results are copied out only at the end so out_bin keeps the previous value during CONV
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         b.in_ready <= 1'b1;
         b.out_valid <= 1'b0;
         b.out_bin <= '0;
         b.out_err <= 1'b0;
         busy <= 1'b0;
         acc <= '0;
         cnt <= '0;
         sr <= '0;
         err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (b.in_valid) begin
               sr <= b.in_bcd;
               acc <= '0;
               cnt <= '0;
               err <= 1'b0;
               state <= CONV;
               b.in_ready <= 1'b0;
               busy <= 1'b1;
            end
            CONV: begin
               acc <= nacc;
               sr <= sr << 4;
               cnt <= cnt + 1'b1;
               err <= err | bad;
               if (last) begin
                  state <= DONE;
                  b.out_valid <= 1'b1;
                  b.out_bin <= nacc;
                  b.out_err <= err | bad;
               end
            end
            DONE: if (b.out_ready) begin
               state <= IDLE;
               b.out_valid <= 1'b0;
               b.in_ready <= 1'b1;
               busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/bcd_conv_sequencer.md
BCD_CONV_SEQUENCER -- requirements
Module: bcd_conv_sequencer

Interface
REQ-001 The block SHALL have parameter NDIG, default 8, meaning the number of BCD digits per input word (1..300).
REQ-002 The block SHALL have parameter OUT_W, default 27, meaning the binary result width; OUT_W >= ceil(log2(10^NDIG)) is required.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  input word offered.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 in_bcd  input  4*NDIG  packed BCD; digit NDIG-1 (MSD) in bits [4*NDIG-1:4*NDIG-4].
REQ-008 out_valid  output  1  result held and valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_bin  output  OUT_W  binary value of the accepted BCD word.
REQ-011 out_err  output  1  at least one digit of the word was > 9.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CONV, DONE.
REQ-014 In IDLE: in_ready = 1, out_valid = 0.
REQ-015 IDLE, accept on the edge with in_valid & in_ready: latch in_bcd into the digit shift register; clear the accumulator, digit counter and error flag; go to CONV.
REQ-016 In CONV: one digit per cycle, MSD first.
- acc <= (acc*10 + d) mod 2^OUT_W, where d is the current top digit.
- Shift register moves left 4 bits.
- Counter increments.
REQ-017 A digit d > 9 SHALL contribute 0 to the accumulator and set the error flag, which is sticky until the next accept.
REQ-018 CONV SHALL go to DONE on the edge that processes digit 0 (counter = NDIG-1); CONV therefore lasts exactly NDIG cycles.
REQ-019 Latency: if the accept occurs on edge k, out_valid SHALL rise after edge k+NDIG.
REQ-020 In DONE:
- out_valid = 1.
- out_bin and out_err are stable.
- in_ready = 0.
REQ-021 In DONE, out_valid & out_ready on an edge SHALL return the FSM to IDLE, with out_valid low after that edge.
REQ-022 out_valid held without out_ready SHALL keep out_bin and out_err unchanged for any number of cycles.
REQ-023 in_ready SHALL be 0 in CONV and DONE; in_valid and in_bcd are ignored there and no input is lost or merged.
REQ-024 Minimum spacing between accepts SHALL be NDIG+2 cycles (accept, NDIG conversion cycles, DONE handshake, IDLE).
REQ-025 out_bin SHALL hold the last result in IDLE; it is meaningful only while out_valid = 1.
REQ-026 Arithmetic SHALL be unsigned; multiply-by-10 is formed as (acc<<3)+(acc<<1), truncated to OUT_W bits.

Reset
REQ-027 On reset assertion, the following SHALL be cleared immediately (asynchronously), regardless of state:
- state = IDLE.
- out_valid = 0, out_bin = 0, out_err = 0, busy = 0.
- Accumulator, counter and shift register = 0.
REQ-028 Reset mid-CONV or mid-DONE SHALL abort the word with no out_valid pulse.
REQ-029 in_ready SHALL read 1 on the first cycle after reset deasserts.

Verification
REQ-030 NDIG=8: in_bcd=32'h12345678 accepted on edge k -> out_valid after edge k+8, out_bin=12345678 (27'h0BC614E), out_err=0.
REQ-031 in_bcd=32'h99999999 -> out_bin=99999999 (27'h5F5E0FF), out_err=0; in_bcd=32'h00000000 -> out_bin=0.
REQ-032 in_bcd=32'h0000001A -> out_bin=10, out_err=1; the next word, 32'h00000042, -> out_bin=42, out_err=0 (error flag not carried over).
REQ-033 out_ready held low 5 cycles in DONE -> out_valid, out_bin and out_err constant; in_ready=0 throughout; in_valid pulses in that window are not accepted.
REQ-034 Reset pulsed 3 cycles after accept -> out_valid never rises; in_ready=1 after deassert; a new word of 32'h00000007 -> out_bin=7.
REQ-035 Back-to-back words with in_valid and out_ready held high -> accepts exactly NDIG+2 cycles apart, and each result is correct.
